// File: rtl/onehot_rr_arbiter_if.sv
// Handshake bundle between requesters/consumer and the one-hot round-robin arbiter.
// The master side drives requests and done; the slave side (arbiter) returns the grant.
interface onehot_rr_arbiter_if #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_valid, grant_idx, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_valid, grant_idx, timeout
    );
endinterface

// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant for the downstream data mux.
// A grant is held until done, requester drop, or the optional hold-limit timeout.
//
// state | meaning
// IDLE  | no grant held; arbitrate from ptr on the next edge
// BUSY  | grant held; watch for release or hold-limit expiry
module onehot_rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_rr_arbiter_if.slave    bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam bit TMO_EN = (MAX_HOLD > 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = TMO_EN ? HOLD_W'(MAX_HOLD - 1) : '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;

    logic              hi_found;
    logic [IDX_W-1:0]  hi_win, lo_win, win;
    logic              release_now, tmo_hit;

    // Lowest set request at or above ptr wins; otherwise wrap to the lowest below ptr.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = '0;
        lo_win   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                if (IDX_W'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = IDX_W'(j);
                end else begin
                    lo_win   = IDX_W'(j);
                end
            end
        end
        win = hi_found ? hi_win : lo_win;
    end

    assign release_now = bus.done || !bus.req[idx_q];
    assign tmo_hit     = TMO_EN && (hold_q == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << win;
                    idx_d   = win;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                // done/drop outranks the hold limit, so a coinciding done suppresses timeout.
                if (release_now || tmo_hit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    idx_d     = '0;
                    ptr_d     = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
                    timeout_d = !release_now;
                end else if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = |grant_q;
    assign bus.grant_idx   = idx_q;
    assign bus.timeout     = timeout_q;

endmodule
